// File: rtl/riscv_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM states, trace
// causes and the bundled per-stage control word.
package riscv_pkg;

    typedef enum logic [1:0] {
        RUN,
        MDU_WAIT,
        MEM_WAIT
    } pipe_ctrl_state_e;

    typedef enum logic [2:0] {
        NONE,
        LOAD_USE,
        MDU,
        MEM,
        BRANCH
    } stall_cause_e;

    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic stall_m;
        logic flush_d;
        logic flush_e;
        logic bubble_m;
        logic bubble_w;
    } pipe_ctrl_t;

    // Each cause maps to exactly one stall/flush pattern.
    function automatic pipe_ctrl_t ctrl_for_cause(input stall_cause_e cause);
        pipe_ctrl_t c;
        c = '0;
        case (cause)
            MEM: begin
                c.stall_f  = 1'b1;
                c.stall_d  = 1'b1;
                c.stall_e  = 1'b1;
                c.stall_m  = 1'b1;
                c.bubble_w = 1'b1;
            end
            MDU: begin
                c.stall_f  = 1'b1;
                c.stall_d  = 1'b1;
                c.stall_e  = 1'b1;
                c.bubble_m = 1'b1;
            end
            BRANCH: begin
                c.flush_d = 1'b1;
                c.flush_e = 1'b1;
            end
            LOAD_USE: begin
                c.stall_f = 1'b1;
                c.stall_d = 1'b1;
                c.flush_e = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_load_use_detect.sv
// Combinational load-use hazard detector: the D instruction reads a register
// that the load currently in E has not yet produced.
module load_use_detect (
    input  logic [4:0] rs1_i,
    input  logic [4:0] rs2_i,
    input  logic       rs1_used_i,
    input  logic       rs2_used_i,
    input  logic [4:0] rd_i,
    input  logic       load_i,
    output logic       hazard_o
);

    logic rs1_match;
    logic rs2_match;

    always_comb begin
        rs1_match = rs1_used_i && (rs1_i == rd_i);
        rs2_match = rs2_used_i && (rs2_i == rd_i);
        // x0 is hardwired to zero, so a load into it never creates a dependency
        hazard_o  = load_i && (rd_i != 5'd0) && (rs1_match || rs2_match);
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory waits, MDU waits,
// branch redirects and load-use stalls, plus a saturating stall-cycle counter.
module pipeline_ctrl
    import riscv_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       rs1D_i,
    input  logic [4:0]       rs2D_i,
    input  logic             rs1_usedD_i,
    input  logic             rs2_usedD_i,
    input  logic [4:0]       rdE_i,
    input  logic             loadE_i,
    input  logic             branch_takenE_i,
    input  logic             mdu_startE_i,
    input  logic             mdu_done_i,
    input  logic             dmem_reqM_i,
    input  logic             dmem_ack_i,
    output logic             stallF_o,
    output logic             stallD_o,
    output logic             stallE_o,
    output logic             stallM_o,
    output logic             flushD_o,
    output logic             flushE_o,
    output logic             bubbleM_o,
    output logic             bubbleW_o,
    output logic             mdu_go_o,
    output logic             bus_err_o,
    output logic [CNT_W-1:0] stall_cycles_o
);

    localparam int              WCNT_W   = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

    pipe_ctrl_state_e  state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;

    logic         load_use;
    logic         mem_hold;
    logic         mem_timeout;
    logic         mdu_hold;
    logic         mdu_go;
    stall_cause_e cause;
    pipe_ctrl_t   ctrl;

    load_use_detect u_load_use_detect (
        .rs1_i      (rs1D_i),
        .rs2_i      (rs2D_i),
        .rs1_used_i (rs1_usedD_i),
        .rs2_used_i (rs2_usedD_i),
        .rd_i       (rdE_i),
        .load_i     (loadE_i),
        .hazard_o   (load_use)
    );

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        cause       = NONE;

        mem_hold    = ((state_q == RUN) && dmem_reqM_i && !dmem_ack_i) ||
                      ((state_q == MEM_WAIT) && !dmem_ack_i && (wcnt_q < WAIT_LAST));
        mem_timeout = (state_q == MEM_WAIT) && !dmem_ack_i && (wcnt_q == WAIT_LAST);
        mdu_hold    = ((state_q == RUN) && mdu_startE_i) ||
                      ((state_q == MDU_WAIT) && !mdu_done_i);
        mdu_go      = !mem_hold && (state_q == RUN) && mdu_startE_i;

        if (mem_hold) begin
            cause = MEM;
        end else if (mdu_hold) begin
            cause = MDU;
        end else if (branch_takenE_i) begin
            cause = BRANCH;
        end else if (load_use) begin
            cause = LOAD_USE;
        end

        // The request cycle is wait cycle 0, so the register enters MEM_WAIT
        // already holding 1; timeout then lands on total cycle MEM_TIMEOUT.
        case (state_q)
            RUN: begin
                if (mem_hold) begin
                    state_d = MEM_WAIT;
                    wcnt_d  = WCNT_W'(1);
                end else if (mdu_go) begin
                    state_d = MDU_WAIT;
                end
            end
            MEM_WAIT: begin
                if (dmem_ack_i || mem_timeout) begin
                    state_d = RUN;
                    wcnt_d  = '0;
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            MDU_WAIT: begin
                if (mdu_done_i) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                wcnt_d  = '0;
            end
        endcase

        if (rst_i) begin
            cause = NONE;
        end
        ctrl = ctrl_for_cause(cause);

        stall_cycles_d = stall_cycles_q;
        if (ctrl.stall_f && !(&stall_cycles_q)) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= RUN;
            wcnt_q         <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            wcnt_q         <= wcnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stallF_o       = ctrl.stall_f;
    assign stallD_o       = ctrl.stall_d;
    assign stallE_o       = ctrl.stall_e;
    assign stallM_o       = ctrl.stall_m;
    assign flushD_o       = ctrl.flush_d;
    assign flushE_o       = ctrl.flush_e;
    assign bubbleM_o      = ctrl.bubble_m;
    assign bubbleW_o      = ctrl.bubble_w;
    assign mdu_go_o       = mdu_go && !rst_i;
    assign bus_err_o      = mem_timeout && !rst_i;
    assign stall_cycles_o = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus a randomized
// run against a cycle-level behavioural model of the stall rules.
module tb_pipeline_ctrl;

    localparam int TMO  = 16;
    localparam int CW   = 6;
    localparam int CMAX = (1 << CW) - 1;

    // Observation order: stallF stallD stallE stallM flushD flushE bubbleM bubbleW mdu_go bus_err
    localparam logic [9:0] C_NONE     = 10'b00000000_00;
    localparam logic [9:0] C_LU       = 10'b11000100_00;
    localparam logic [9:0] C_BR       = 10'b00001100_00;
    localparam logic [9:0] C_MDU_GO   = 10'b11100010_10;
    localparam logic [9:0] C_MDU_HOLD = 10'b11100010_00;
    localparam logic [9:0] C_MEM      = 10'b11110001_00;
    localparam logic [9:0] C_ERR      = 10'b00000000_01;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [4:0]    rs1D, rs2D, rdE;
    logic          rs1_used, rs2_used, loadE, taken, start, done, req, ack;
    logic          stallF, stallD, stallE, stallM, flushD, flushE, bubbleM, bubbleW;
    logic          mdu_go, bus_err;
    logic [CW-1:0] stall_cycles;
    logic [9:0]    obs;

    int vectors     = 0;
    int miscompares = 0;

    pipeline_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .rs1D_i          (rs1D),
        .rs2D_i          (rs2D),
        .rs1_usedD_i     (rs1_used),
        .rs2_usedD_i     (rs2_used),
        .rdE_i           (rdE),
        .loadE_i         (loadE),
        .branch_takenE_i (taken),
        .mdu_startE_i    (start),
        .mdu_done_i      (done),
        .dmem_reqM_i     (req),
        .dmem_ack_i      (ack),
        .stallF_o        (stallF),
        .stallD_o        (stallD),
        .stallE_o        (stallE),
        .stallM_o        (stallM),
        .flushD_o        (flushD),
        .flushE_o        (flushE),
        .bubbleM_o       (bubbleM),
        .bubbleW_o       (bubbleW),
        .mdu_go_o        (mdu_go),
        .bus_err_o       (bus_err),
        .stall_cycles_o  (stall_cycles)
    );

    assign obs = {stallF, stallD, stallE, stallM, flushD, flushE, bubbleM, bubbleW, mdu_go, bus_err};

    task automatic idle();
        rs1D = 5'd0; rs2D = 5'd0; rdE = 5'd0;
        rs1_used = 1'b0; rs2_used = 1'b0; loadE = 1'b0; taken = 1'b0;
        start = 1'b0; done = 1'b0; req = 1'b0; ack = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        idle();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        loadE = 1'b1; rdE = 5'd3; rs1D = 5'd3; rs1_used = 1'b1;
        req = 1'b1; start = 1'b1;
        @(negedge clk);
        vectors++;
        if (obs !== C_NONE) begin
            miscompares++;
            $display("FAIL reset_outs: got %b want %b", obs, C_NONE);
        end
        vectors++;
        if (stall_cycles !== '0) begin
            miscompares++;
            $display("FAIL reset_cnt: got %0d want 0", stall_cycles);
        end
        next_cycle();
        idle();
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_load_use();
        apply_reset();
        loadE = 1'b1; rdE = 5'd5; rs2D = 5'd5; rs2_used = 1'b1; rs1D = 5'd3; rs1_used = 1'b1;
        @(negedge clk);
        vectors++;
        if (obs !== C_LU) begin
            miscompares++;
            $display("FAIL lu_rs2: got %b want %b", obs, C_LU);
        end
        next_cycle();
        loadE = 1'b0;
        @(negedge clk);
        vectors++;
        if (obs !== C_NONE) begin
            miscompares++;
            $display("FAIL lu_release: got %b want %b", obs, C_NONE);
        end
        next_cycle();
        loadE = 1'b1; rdE = 5'd0; rs2D = 5'd0;
        @(negedge clk);
        vectors++;
        if (obs !== C_NONE) begin
            miscompares++;
            $display("FAIL lu_x0: got %b want %b", obs, C_NONE);
        end
        next_cycle();
        rdE = 5'd5; rs2D = 5'd5; rs2_used = 1'b0;
        @(negedge clk);
        vectors++;
        if (obs !== C_NONE) begin
            miscompares++;
            $display("FAIL lu_unused: got %b want %b", obs, C_NONE);
        end
        next_cycle();
        rdE = 5'd7; rs1D = 5'd7; rs1_used = 1'b1;
        @(negedge clk);
        vectors++;
        if (obs !== C_LU) begin
            miscompares++;
            $display("FAIL lu_rs1: got %b want %b", obs, C_LU);
        end
        next_cycle();
        idle();
        @(negedge clk);
        vectors++;
        if (stall_cycles !== CW'(2)) begin
            miscompares++;
            $display("FAIL lu_cnt: got %0d want 2", stall_cycles);
        end
        next_cycle();
    endtask

    task automatic test_branch();
        apply_reset();
        loadE = 1'b1; rdE = 5'd9; rs1D = 5'd9; rs1_used = 1'b1; taken = 1'b1;
        @(negedge clk);
        vectors++;
        if (obs !== C_BR) begin
            miscompares++;
            $display("FAIL br_over_lu: got %b want %b", obs, C_BR);
        end
        next_cycle();
        idle();
        taken = 1'b1;
        @(negedge clk);
        vectors++;
        if (obs !== C_BR) begin
            miscompares++;
            $display("FAIL br_plain: got %b want %b", obs, C_BR);
        end
        next_cycle();
        idle();
    endtask

    task automatic test_mdu();
        apply_reset();
        start = 1'b1;
        @(negedge clk);
        vectors++;
        if (obs !== C_MDU_GO) begin
            miscompares++;
            $display("FAIL mdu_go: got %b want %b", obs, C_MDU_GO);
        end
        next_cycle();
        for (int i = 1; i < 4; i++) begin
            taken = (i == 2);
            @(negedge clk);
            vectors++;
            if (obs !== C_MDU_HOLD) begin
                miscompares++;
                $display("FAIL mdu_hold%0d: got %b want %b", i, obs, C_MDU_HOLD);
            end
            next_cycle();
        end
        taken = 1'b0;
        done = 1'b1;
        @(negedge clk);
        vectors++;
        if (obs !== C_NONE) begin
            miscompares++;
            $display("FAIL mdu_done: got %b want %b", obs, C_NONE);
        end
        next_cycle();
        idle();
        done = 1'b1;
        @(negedge clk);
        vectors++;
        if (obs !== C_NONE) begin
            miscompares++;
            $display("FAIL mdu_done_in_run: got %b want %b", obs, C_NONE);
        end
        vectors++;
        if (stall_cycles !== CW'(4)) begin
            miscompares++;
            $display("FAIL mdu_cnt: got %0d want 4", stall_cycles);
        end
        next_cycle();
        idle();
    endtask

    task automatic test_mem();
        apply_reset();
        req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (obs !== C_MEM) begin
                miscompares++;
                $display("FAIL mem_hold%0d: got %b want %b", i, obs, C_MEM);
            end
            next_cycle();
        end
        ack = 1'b1;
        @(negedge clk);
        vectors++;
        if (obs !== C_NONE) begin
            miscompares++;
            $display("FAIL mem_ack: got %b want %b", obs, C_NONE);
        end
        next_cycle();
        req = 1'b1; ack = 1'b1;
        @(negedge clk);
        vectors++;
        if (obs !== C_NONE) begin
            miscompares++;
            $display("FAIL mem_ack_same: got %b want %b", obs, C_NONE);
        end
        next_cycle();
        idle();
        @(negedge clk);
        vectors++;
        if (stall_cycles !== CW'(3)) begin
            miscompares++;
            $display("FAIL mem_cnt: got %0d want 3", stall_cycles);
        end
        next_cycle();
    endtask

    task automatic test_timeout();
        apply_reset();
        req = 1'b1;
        for (int i = 1; i < TMO; i++) begin
            @(negedge clk);
            vectors++;
            if (obs !== C_MEM) begin
                miscompares++;
                $display("FAIL tmo_hold%0d: got %b want %b", i, obs, C_MEM);
            end
            next_cycle();
        end
        @(negedge clk);
        vectors++;
        if (obs !== C_ERR) begin
            miscompares++;
            $display("FAIL tmo_err: got %b want %b", obs, C_ERR);
        end
        next_cycle();
        idle();
        start = 1'b1;
        @(negedge clk);
        vectors++;
        if (obs !== C_MDU_GO) begin
            miscompares++;
            $display("FAIL tmo_back_to_run: got %b want %b", obs, C_MDU_GO);
        end
        vectors++;
        if (stall_cycles !== CW'(TMO - 1)) begin
            miscompares++;
            $display("FAIL tmo_cnt: got %0d want %0d", stall_cycles, TMO - 1);
        end
        next_cycle();
        idle();
        done = 1'b1;
        next_cycle();
        idle();
    endtask

    task automatic test_reset_mid_mdu();
        apply_reset();
        start = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (obs !== C_NONE) begin
            miscompares++;
            $display("FAIL rstmid_during: got %b want %b", obs, C_NONE);
        end
        next_cycle();
        rst = 1'b0;
        idle();
        @(negedge clk);
        vectors++;
        if (obs !== C_NONE) begin
            miscompares++;
            $display("FAIL rstmid_after: got %b want %b", obs, C_NONE);
        end
        vectors++;
        if (stall_cycles !== '0) begin
            miscompares++;
            $display("FAIL rstmid_cnt: got %0d want 0", stall_cycles);
        end
        next_cycle();
        done = 1'b1;
        @(negedge clk);
        vectors++;
        if (obs !== C_NONE) begin
            miscompares++;
            $display("FAIL rstmid_late_done: got %b want %b", obs, C_NONE);
        end
        next_cycle();
        done = 1'b0;
        start = 1'b1;
        @(negedge clk);
        vectors++;
        if (obs !== C_MDU_GO) begin
            miscompares++;
            $display("FAIL rstmid_run: got %b want %b", obs, C_MDU_GO);
        end
        next_cycle();
        start = 1'b0;
        done = 1'b1;
        next_cycle();
        idle();
    endtask

    // Behavioural reference: tracks which wait is outstanding and how many
    // cycles have elapsed since the memory request was first presented.
    task automatic test_random();
        bit          m_mem_wait, m_mdu_wait;
        int          m_elapsed, m_cnt;
        bit          mem_stall, mdu_stall, go, err, hz;
        logic [9:0]  exp;
        apply_reset();
        m_mem_wait = 0; m_mdu_wait = 0; m_elapsed = 0; m_cnt = 0;
        for (int n = 0; n < 3000; n++) begin
            rst      = ($urandom_range(199) == 0);
            rs1D     = 5'($urandom_range(3));
            rs2D     = 5'($urandom_range(3));
            rdE      = 5'($urandom_range(3));
            rs1_used = 1'($urandom_range(1));
            rs2_used = 1'($urandom_range(1));
            loadE    = 1'($urandom_range(1));
            taken    = ($urandom_range(5) == 0);
            if (m_mdu_wait) begin
                req   = 1'b0;
                ack   = 1'b0;
                start = 1'($urandom_range(1));
                done  = ($urandom_range(3) == 0);
            end else if (m_mem_wait) begin
                req   = 1'b1;
                ack   = ($urandom_range(5) == 0);
                start = ($urandom_range(4) == 0);
                done  = 1'b0;
            end else begin
                req   = ($urandom_range(4) == 0);
                ack   = req && ($urandom_range(2) == 0);
                start = ($urandom_range(4) == 0);
                done  = 1'b0;
            end

            hz        = loadE && (rdE != 5'd0) &&
                        ((rs1_used && rs1D == rdE) || (rs2_used && rs2D == rdE));
            mem_stall = (!m_mem_wait && !m_mdu_wait && req && !ack) ||
                        (m_mem_wait && !ack && m_elapsed < TMO - 1);
            err       = m_mem_wait && !ack && m_elapsed == TMO - 1;
            go        = !mem_stall && !m_mem_wait && !m_mdu_wait && start;
            mdu_stall = !mem_stall && (go || (m_mdu_wait && !done));

            if (rst)            exp = C_NONE;
            else if (mem_stall) exp = C_MEM;
            else if (mdu_stall) exp = go ? C_MDU_GO : C_MDU_HOLD;
            else begin
                exp = taken ? C_BR : (hz ? C_LU : C_NONE);
                if (err) exp = exp | C_ERR;
            end

            @(negedge clk);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL rand_outs@%0d: got %b want %b", n, obs, exp);
            end
            vectors++;
            if (stall_cycles !== CW'(m_cnt)) begin
                miscompares++;
                $display("FAIL rand_cnt@%0d: got %0d want %0d", n, stall_cycles, m_cnt);
            end

            if (rst) begin
                m_mem_wait = 0; m_mdu_wait = 0; m_elapsed = 0; m_cnt = 0;
            end else begin
                if (exp[9] && m_cnt < CMAX) m_cnt++;
                if (m_mem_wait) begin
                    if (ack || err) m_mem_wait = 0;
                    else m_elapsed++;
                end else if (m_mdu_wait) begin
                    if (done) m_mdu_wait = 0;
                end else if (mem_stall) begin
                    m_mem_wait = 1;
                    m_elapsed  = 1;
                end else if (go) begin
                    m_mdu_wait = 1;
                end
            end
            next_cycle();
        end
        idle();
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        rst = 1'b1;
        test_reset();
        test_load_use();
        test_branch();
        test_mdu();
        test_mem();
        test_timeout();
        test_reset_mid_mdu();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
